// File: rtl/bus_link_xbar.sv
// bus_link_xbar - N-node interconnect for inter-bus bridge traffic.
//
// Each node's bridge master pushes {dest, data}. Words are buffered in one
// first-word-fall-through FIFO per destination; competing sources for the
// same destination are arbitrated round-robin, and each delivered word
// carries the ID of the source that issued it.
//
// Ports
//   clock      system clock, all state on rising edge
//   rst        asynchronous active-low reset
//   src_valid  [N]        node s offers a word
//   src_dest   [N*ID_W]   destination ID of node s (ignored in RING_MODE)
//   src_data   [N*DATA_W] payload of node s
//   src_ready  [N]        word of node s accepted or dropped this cycle
//   src_drop   [N]        one-cycle pulse: last cycle's word from s was dropped
//   dst_valid  [N]        FIFO d holds at least one word
//   dst_data   [N*DATA_W] head payload of FIFO d
//   dst_src    [N*ID_W]   source ID of head word of FIFO d
//   dst_ready  [N]        node d consumes the head word
//   fifo_full  [N]        FIFO d holds DEPTH words

// Per-destination FIFO: registered storage, head read straight from memory.
module bus_link_fifo #(
   parameter int W     = 22,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_ent,
   input  logic         pop,
   output logic         valid,
   output logic         full,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          push_ok, pop_ok;

   assign valid   = (cnt != '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign push_ok = push & ~full;
   assign pop_ok  = pop & valid;
   assign head    = mem[rp];

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         if (pop_ok)  rp <= rp + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is not reset: contents are don't-care while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wp] <= push_ent;
   end
endmodule

module bus_link_xbar #(
   parameter int N_NODES   = 3,
   parameter int ID_W      = 2,
   parameter int DATA_W    = 20,
   parameter int DEPTH     = 4,
   parameter bit RING_MODE = 1'b0
) (
   input  logic                      clock,
   input  logic                      rst,
   input  logic [N_NODES-1:0]        src_valid,
   input  logic [N_NODES*ID_W-1:0]   src_dest,
   input  logic [N_NODES*DATA_W-1:0] src_data,
   output logic [N_NODES-1:0]        src_ready,
   output logic [N_NODES-1:0]        src_drop,
   output logic [N_NODES-1:0]        dst_valid,
   output logic [N_NODES*DATA_W-1:0] dst_data,
   output logic [N_NODES*ID_W-1:0]   dst_src,
   input  logic [N_NODES-1:0]        dst_ready,
   output logic [N_NODES-1:0]        fifo_full
);
   localparam int EW = ID_W + DATA_W;

   logic [N_NODES-1:0][ID_W-1:0]    eff;      // effective dest per source
   logic [N_NODES-1:0]              inv;      // source offers an unroutable word
   logic [N_NODES-1:0][N_NODES-1:0] cand;     // [dest][src]
   logic [N_NODES-1:0][N_NODES-1:0] gnt;      // [dest][src]
   logic [N_NODES-1:0][ID_W-1:0]    gnt_idx;
   logic [N_NODES-1:0][ID_W-1:0]    rr_q;
   logic [N_NODES-1:0][EW-1:0]      push_ent;
   logic [N_NODES-1:0][EW-1:0]      head;
   logic [N_NODES-1:0]              push;

   always_comb begin
      eff  = '0;
      inv  = '0;
      cand = '0;
      for (int s = 0; s < N_NODES; s++) begin
         if (RING_MODE) eff[s] = ID_W'((s + 1) % N_NODES);
         else           eff[s] = src_dest[s*ID_W +: ID_W];
         inv[s] = src_valid[s] &&
                  ((int'(eff[s]) >= N_NODES) || (!RING_MODE && int'(eff[s]) == s));
         for (int d = 0; d < N_NODES; d++)
            cand[d][s] = src_valid[s] && !inv[s] && (int'(eff[s]) == d);
      end
   end

   // Round-robin: search sources above rr_q first, then wrap to 0..rr_q.
   // A full FIFO grants nothing, independent of a same-cycle pop, so that
   // src_ready never depends on dst_ready.
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      push_ent = '0;
      for (int d = 0; d < N_NODES; d++) begin
         logic found;
         found = 1'b0;
         for (int s = 0; s < N_NODES; s++) begin
            if (!found && !fifo_full[d] && cand[d][s] && s > int'(rr_q[d])) begin
               gnt[d][s]  = 1'b1;
               gnt_idx[d] = ID_W'(s);
               found      = 1'b1;
            end
         end
         for (int s = 0; s < N_NODES; s++) begin
            if (!found && !fifo_full[d] && cand[d][s] && s <= int'(rr_q[d])) begin
               gnt[d][s]  = 1'b1;
               gnt_idx[d] = ID_W'(s);
               found      = 1'b1;
            end
         end
         for (int s = 0; s < N_NODES; s++)
            if (gnt[d][s]) push_ent[d] = {ID_W'(s), src_data[s*DATA_W +: DATA_W]};
      end
   end

   always_comb begin
      src_ready = inv;
      push      = '0;
      for (int d = 0; d < N_NODES; d++) begin
         push[d]   = |gnt[d];
         src_ready = src_ready | gnt[d];
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < N_NODES; d++) rr_q[d] <= ID_W'(N_NODES - 1);
         src_drop <= '0;
      end else begin
         for (int d = 0; d < N_NODES; d++)
            if (push[d]) rr_q[d] <= gnt_idx[d];
         src_drop <= inv;
      end
   end

   for (genvar d = 0; d < N_NODES; d++) begin : g_dst
      bus_link_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
         .clock    (clock),
         .rst      (rst),
         .push     (push[d]),
         .push_ent (push_ent[d]),
         .pop      (dst_ready[d]),
         .valid    (dst_valid[d]),
         .full     (fifo_full[d]),
         .head     (head[d])
      );
      assign dst_data[d*DATA_W +: DATA_W] = head[d][DATA_W-1:0];
      assign dst_src[d*ID_W +: ID_W]      = head[d][EW-1:DATA_W];
   end
endmodule

// File: tb/tb_bus_link_xbar.sv
// Directed bench: one xbar instance in dest-field mode and one in ring mode,
// sharing clock and reset.
module tb_bus_link_xbar;
   localparam int N = 3, IW = 2, DW = 20, DEPTH = 4;

   logic clock = 1'b0;
   logic rst   = 1'b0;
   always #5 clock = ~clock;

   // dest-field instance
   logic [N-1:0]    x_sv, x_srdy, x_drop, x_dv, x_drdy, x_full;
   logic [N*IW-1:0] x_sd, x_dsrc;
   logic [N*DW-1:0] x_sdat, x_ddat;
   // ring instance
   logic [N-1:0]    r_sv, r_srdy, r_drop, r_dv, r_drdy, r_full;
   logic [N*IW-1:0] r_sd, r_dsrc;
   logic [N*DW-1:0] r_sdat, r_ddat;

   int n_cmp = 0;
   int n_err = 0;

   bus_link_xbar #(.N_NODES(N), .ID_W(IW), .DATA_W(DW), .DEPTH(DEPTH), .RING_MODE(1'b0)) u_xbar (
      .clock(clock), .rst(rst), .src_valid(x_sv), .src_dest(x_sd), .src_data(x_sdat),
      .src_ready(x_srdy), .src_drop(x_drop), .dst_valid(x_dv), .dst_data(x_ddat),
      .dst_src(x_dsrc), .dst_ready(x_drdy), .fifo_full(x_full));

   bus_link_xbar #(.N_NODES(N), .ID_W(IW), .DATA_W(DW), .DEPTH(DEPTH), .RING_MODE(1'b1)) u_ring (
      .clock(clock), .rst(rst), .src_valid(r_sv), .src_dest(r_sd), .src_data(r_sdat),
      .src_ready(r_srdy), .src_drop(r_drop), .dst_valid(r_dv), .dst_data(r_ddat),
      .dst_src(r_dsrc), .dst_ready(r_drdy), .fifo_full(r_full));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      x_sv = '1; x_sd = '0; x_sdat = '0; x_drdy = '0;
      r_sv = '1; r_sd = '0; r_sdat = '0; r_drdy = '0;

      // reset held with all sources valid
      tick(); tick();
      chk("rst_x_dv",   32'(x_dv),   32'h0);
      chk("rst_x_full", 32'(x_full), 32'h0);
      chk("rst_x_drop", 32'(x_drop), 32'h0);
      chk("rst_r_dv",   32'(r_dv),   32'h0);
      chk("rst_r_full", 32'(r_full), 32'h0);
      x_sv = '0; r_sv = '0;
      rst = 1'b1;
      tick();

      // ring: node0 -> node1
      r_sv = 3'b001; r_sdat = {20'h0, 20'h0, 20'h12345};
      #1 chk("ring_srdy", 32'(r_srdy), 32'h1);
      tick();
      r_sv = '0;
      chk("ring_dv",   32'(r_dv),            32'h2);
      chk("ring_data", 32'(r_ddat[DW +: DW]), 32'h12345);
      chk("ring_src",  32'(r_dsrc[IW +: IW]), 32'h0);
      r_drdy = 3'b010;
      tick();
      r_drdy = '0;
      chk("ring_empty", 32'(r_dv), 32'h0);

      // contention: src0 and src2 both to dest 1, consumer always ready
      x_sd = {2'd1, 2'd0, 2'd1}; x_sdat = {20'h33333, 20'h0, 20'h11111};
      x_sv = 3'b101; x_drdy = 3'b010;
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("cont_srdy%0d", k), 32'(x_srdy), (k % 2 == 0) ? 32'h1 : 32'h4);
         tick();
         chk($sformatf("cont_src%0d", k),  32'(x_dsrc[IW +: IW]), (k % 2 == 0) ? 32'h0 : 32'h2);
         chk($sformatf("cont_data%0d", k), 32'(x_ddat[DW +: DW]), (k % 2 == 0) ? 32'h11111 : 32'h33333);
      end
      x_sv = '0;
      tick();
      x_drdy = '0;
      chk("cont_drain", 32'(x_dv), 32'h0);

      // full: five words from src0 to dest 2, consumer stalled
      x_sd = {2'd0, 2'd0, 2'd2};
      for (int i = 1; i <= 4; i++) begin
         x_sdat = {40'h0, 20'h50000 + 20'(i)}; x_sv = 3'b001;
         #1 chk($sformatf("full_srdy%0d", i), 32'(x_srdy[0]), 32'h1);
         tick();
      end
      chk("full_flag", 32'(x_full), 32'h4);
      x_sdat = {40'h0, 20'h50005};
      #1 chk("full_hold", 32'(x_srdy[0]), 32'h0);
      tick();
      chk("full_hold2", 32'(x_srdy[0]), 32'h0);
      x_drdy = 3'b100;
      #1 chk("full_nopath", 32'(x_srdy[0]), 32'h0);
      chk("full_head1", 32'(x_ddat[2*DW +: DW]), 32'h50001);
      tick();
      x_drdy = '0;
      chk("full_clear", 32'(x_full), 32'h0);
      chk("full_accept5", 32'(x_srdy[0]), 32'h1);
      tick();
      x_sv = '0;
      chk("full_again", 32'(x_full), 32'h4);
      x_drdy = 3'b100;
      for (int i = 2; i <= 5; i++) begin
         chk($sformatf("full_order%0d", i), 32'(x_ddat[2*DW +: DW]), 32'h50000 + 32'(i));
         tick();
      end
      x_drdy = '0;
      chk("full_empty", 32'(x_dv), 32'h0);

      // invalid destinations: self, then out of range
      x_sv = 3'b010; x_sd = {2'd0, 2'd1, 2'd0}; x_sdat = {20'h0, 20'hDEAD1, 20'h0};
      #1 chk("inv_self_srdy", 32'(x_srdy), 32'h2);
      tick();
      x_sv = '0;
      chk("inv_self_drop", 32'(x_drop), 32'h2);
      chk("inv_self_dv",   32'(x_dv),   32'h0);
      tick();
      chk("inv_self_pulse", 32'(x_drop), 32'h0);
      x_sv = 3'b010; x_sd = {2'd0, 2'd3, 2'd0};
      #1 chk("inv_rng_srdy", 32'(x_srdy), 32'h2);
      tick();
      x_sv = '0;
      chk("inv_rng_drop", 32'(x_drop), 32'h2);
      tick();
      chk("inv_rng_pulse", 32'(x_drop), 32'h0);
      chk("inv_rng_dv",    32'(x_dv),   32'h0);
      chk("inv_rng_full",  32'(x_full), 32'h0);

      // pointer wrap: src1 -> dest 0, steady push+pop
      x_sd = {2'd0, 2'd0, 2'd0};
      x_sv = 3'b010; x_sdat = {20'h0, 20'h0A000, 20'h0};
      tick();
      x_drdy = 3'b001;
      for (int i = 1; i <= 10; i++) begin
         x_sdat = {20'h0, 20'h0A000 + 20'(i), 20'h0};
         #1 chk($sformatf("wrap_head%0d", i), 32'(x_ddat[0 +: DW]), 32'h0A000 + 32'(i - 1));
         chk($sformatf("wrap_srdy%0d", i), 32'(x_srdy[1]), 32'h1);
         tick();
         chk($sformatf("wrap_dv%0d", i), 32'(x_dv[0]), 32'h1);
      end
      x_sv = '0;
      chk("wrap_last", 32'(x_ddat[0 +: DW]), 32'h0A00A);
      chk("wrap_src",  32'(x_dsrc[0 +: IW]), 32'h1);
      tick();
      x_drdy = '0;
      chk("wrap_empty", 32'(x_dv), 32'h0);

      // asynchronous reset mid-operation
      x_sv = 3'b001; x_sd = {2'd0, 2'd0, 2'd2}; x_sdat = {40'h0, 20'h77777};
      tick(); tick();
      x_sv = '0;
      chk("mid_pre_dv", 32'(x_dv), 32'h4);
      #2 rst = 1'b0;
      #1 chk("mid_rst_dv", 32'(x_dv), 32'h0);
      chk("mid_rst_full", 32'(x_full), 32'h0);
      rst = 1'b1;
      tick();
      chk("mid_post_dv", 32'(x_dv), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
